// File: rtl/hls_tb_pkg.sv
// Shared types and constants for the HLS run controller.
// State encoding, record status codes and default watchdog limit.
package hls_tb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRST,
    S_START,
    S_WAIT,
    S_REPORT,
    S_FIN
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ABORT   = 2'b10;

  localparam int unsigned TIMEOUT = 200000000;

endpackage

// File: rtl/hls_latency_stats.sv
// Min/max/sum latency accumulator.
// Cleared at campaign start, updated once per accepted ok record.
module hls_latency_stats #(
  parameter int CNT_W = 32,
  parameter int RUN_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   upd,
  input  logic [CNT_W-1:0]       lat,
  output logic [CNT_W-1:0]       stat_min,
  output logic [CNT_W-1:0]       stat_max,
  output logic [CNT_W+RUN_W-1:0] stat_sum
);

  // accumulate; sum wraps naturally at its full width
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_min <= '1;
      stat_max <= '0;
      stat_sum <= '0;
    end else if (clr) begin
      stat_min <= '1;
      stat_max <= '0;
      stat_sum <= '0;
    end else if (upd) begin
      if (lat < stat_min) stat_min <= lat;
      if (lat > stat_max) stat_max <= lat;
      stat_sum <= stat_sum + {{RUN_W{1'b0}}, lat};
    end
  end

endmodule

// File: rtl/hls_run_controller.sv
// Run controller for start/done HLS accelerators.
// Sequences reset/start per run, times it, guards with a watchdog.
module hls_run_controller
  import hls_tb_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int RUN_W       = 16,
  parameter int DRST_CYCLES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cfg_go,
  input  logic [RUN_W-1:0]       cfg_num_runs,
  input  logic [CNT_W-1:0]       cfg_timeout,
  input  logic                   abort,
  output logic                   dut_reset,
  output logic                   dut_start,
  input  logic                   dut_done,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [1:0]             res_status,
  output logic [RUN_W-1:0]       res_run_idx,
  output logic [CNT_W-1:0]       res_latency,
  output logic                   busy,
  output logic                   all_done,
  output logic [CNT_W-1:0]       stat_min,
  output logic [CNT_W-1:0]       stat_max,
  output logic [CNT_W+RUN_W-1:0] stat_sum
);

  localparam int DW = (DRST_CYCLES < 2) ? 1 : $clog2(DRST_CYCLES + 1);
  localparam logic [DW-1:0]    DLAST = DW'(DRST_CYCLES - 1);
  localparam logic [DW-1:0]    DONE1 = DW'(1);
  localparam logic [CNT_W-1:0] CONE  = CNT_W'(1);
  localparam logic [RUN_W:0]   RONE  = (RUN_W+1)'(1);

  state_t           state_q, state_d;
  logic [DW-1:0]    drst_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] to_q;
  logic [RUN_W-1:0] num_q;
  logic [RUN_W-1:0] idx_q;

  logic             go_ok;
  logic             hs;
  logic             wd_hit;
  logic             more;
  logic [CNT_W-1:0] lat_nx;
  logic [RUN_W:0]   idx_nx;

  assign go_ok  = (state_q == S_IDLE) && cfg_go && !abort;
  assign hs     = (state_q == S_REPORT) && res_ready;
  assign wd_hit = (to_q != '0) && (cnt_q == to_q);
  assign lat_nx = (&cnt_q) ? cnt_q : cnt_q + CONE;
  assign idx_nx = {1'b0, idx_q} + RONE;
  assign more   = idx_nx < {1'b0, num_q};

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic; abort outranks done in WAIT
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (go_ok) state_d = S_DRST;
      S_DRST: begin
        if (abort)               state_d = S_FIN;
        else if (drst_q == DLAST) state_d = S_START;
      end
      S_START:  state_d = abort ? S_FIN : S_WAIT;
      S_WAIT:   if (abort || dut_done || wd_hit) state_d = S_REPORT;
      S_REPORT: begin
        if (hs) begin
          if (res_status == ST_OK && !abort && more)
            state_d = S_DRST;
          else
            state_d = S_FIN;
        end
      end
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // config capture, reset-hold timer, latency counter, run index
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drst_q <= '0;
      cnt_q  <= '0;
      to_q   <= '0;
      num_q  <= '0;
      idx_q  <= '0;
    end else begin
      if (go_ok) begin
        to_q  <= cfg_timeout;
        num_q <= (cfg_num_runs == '0) ? RUN_W'(1) : cfg_num_runs;
        idx_q <= '0;
      end
      if (state_q == S_DRST) drst_q <= drst_q + DONE1;
      else                   drst_q <= '0;
      if (state_q == S_START)
        cnt_q <= CONE;
      else if (state_q == S_WAIT && !(&cnt_q))
        cnt_q <= cnt_q + CONE;
      if (hs && state_d == S_DRST)
        idx_q <= idx_nx[RUN_W-1:0];
    end
  end

  // registered outputs and the result record
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dut_reset   <= 1'b1;
      dut_start   <= 1'b0;
      busy        <= 1'b0;
      all_done    <= 1'b0;
      res_valid   <= 1'b0;
      res_status  <= ST_OK;
      res_run_idx <= '0;
      res_latency <= '0;
    end else begin
      dut_reset <= (state_d != S_DRST);
      dut_start <= (state_d == S_START);
      busy      <= (state_d != S_IDLE);
      all_done  <= (state_d == S_FIN);
      res_valid <= (state_d == S_REPORT);
      if (state_q == S_WAIT && state_d == S_REPORT) begin
        res_latency <= lat_nx;
        res_run_idx <= idx_q;
        if (abort)         res_status <= ST_ABORT;
        else if (dut_done) res_status <= ST_OK;
        else               res_status <= ST_TIMEOUT;
      end
    end
  end

  hls_latency_stats #(
    .CNT_W (CNT_W),
    .RUN_W (RUN_W)
  ) u_stats (
    .clock    (clock),
    .reset    (reset),
    .clr      (go_ok),
    .upd      (hs && res_status == ST_OK),
    .lat      (res_latency),
    .stat_min (stat_min),
    .stat_max (stat_max),
    .stat_sum (stat_sum)
  );

endmodule

// File: tb/tb_hls_run_controller.sv
// Directed bench for hls_run_controller.
// Behavioural DUT with per-run done delay; records collected at handshake.
module tb_hls_run_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_go = 1'b0;
  logic [15:0] cfg_num_runs = '0;
  logic [31:0] cfg_timeout = '0;
  logic        abort_r = 1'b0;
  logic        abort_on_done = 1'b0;
  logic        abort;
  logic        dut_reset, dut_start, dut_done;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [1:0]  res_status;
  logic [15:0] res_run_idx;
  logic [31:0] res_latency;
  logic        busy, all_done;
  logic [31:0] stat_min, stat_max;
  logic [47:0] stat_sum;

  int n_vec = 0;
  int n_bad = 0;

  int dly [8];
  int base = 0;
  int nstart = 0;
  int m = 0;
  int cyc = 0;
  int ndone = 0;
  int go_cyc = 0;
  int first_st = 0;
  int last_st = 0;
  int gap = 0;
  bit armed = 0;
  int          q_st [$];
  int          q_idx [$];
  logic [31:0] q_lat [$];

  assign dut_done = (m == 1);
  assign abort = abort_r | (abort_on_done & dut_done);

  always #5 clock = ~clock;

  hls_run_controller dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_go       (cfg_go),
    .cfg_num_runs (cfg_num_runs),
    .cfg_timeout  (cfg_timeout),
    .abort        (abort),
    .dut_reset    (dut_reset),
    .dut_start    (dut_start),
    .dut_done     (dut_done),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_status   (res_status),
    .res_run_idx  (res_run_idx),
    .res_latency  (res_latency),
    .busy         (busy),
    .all_done     (all_done),
    .stat_min     (stat_min),
    .stat_max     (stat_max),
    .stat_sum     (stat_sum)
  );

  // accelerator model and record/event monitor
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset || !dut_reset) m <= 0;
    else if (dut_start) begin
      m <= dly[(nstart - base) & 7];
      nstart <= nstart + 1;
    end else if (m > 0) m <= m - 1;
    if (reset && res_valid && res_ready) begin
      q_st.push_back(int'(res_status));
      q_idx.push_back(int'(res_run_idx));
      q_lat.push_back(res_latency);
    end
    if (all_done) ndone <= ndone + 1;
    if (dut_start) begin
      gap <= cyc - last_st;
      last_st <= cyc;
      if (armed) begin
        first_st <= cyc;
        armed <= 0;
      end
    end
    if (reset && cfg_go && !busy) begin
      go_cyc <= cyc;
      armed <= 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic go(input int n, input int to);
    @(negedge clock);
    cfg_go = 1'b1;
    cfg_num_runs = 16'(n);
    cfg_timeout = 32'(to);
    @(negedge clock);
    cfg_go = 1'b0;
  endtask

  task automatic wait_fin(input int lim);
    int d0 = ndone;
    for (int i = 0; i < lim; i++) begin
      @(negedge clock);
      if (ndone != d0) break;
    end
    chk("fin_wait", 64'(ndone != d0), 64'd1);
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_valid(input int lim);
    bit seen = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clock);
      if (res_valid) begin
        seen = 1;
        break;
      end
    end
    chk("valid_wait", 64'(seen), 64'd1);
  endtask

  task automatic set_dly(input int a, input int b, input int c);
    dly[0] = a;
    dly[1] = b;
    dly[2] = c;
    base = nstart;
  endtask

  initial begin
    int rb, d0, sb;
    bit seen;
    for (int i = 0; i < 8; i++) dly[i] = 5;
    repeat (3) @(negedge clock);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dreset", 64'(dut_reset), 64'd1);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_min", 64'(stat_min), 64'hffff_ffff);
    chk("rst_sum", 64'(stat_sum), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // three runs, fixed delay 5
    set_dly(5, 5, 5);
    rb = q_lat.size();
    d0 = ndone;
    go(3, 1000);
    wait_fin(200);
    chk("t1_nrec", 64'(q_lat.size() - rb), 64'd3);
    for (int k = 0; k < 3; k++) begin
      chk("t1_st", 64'(q_st[rb+k]), 64'd0);
      chk("t1_idx", 64'(q_idx[rb+k]), 64'(k));
      chk("t1_lat", 64'(q_lat[rb+k]), 64'd6);
    end
    chk("t1_done1", 64'(ndone - d0), 64'd1);
    chk("t1_go2st", 64'(first_st - go_cyc), 64'd3);
    chk("t1_gap", 64'(gap), 64'd9);
    chk("t1_min", 64'(stat_min), 64'd6);
    chk("t1_max", 64'(stat_max), 64'd6);
    chk("t1_sum", 64'(stat_sum), 64'd18);
    chk("t1_busy", 64'(busy), 64'd0);

    // delays 3,9,4 with a stall on run 1
    set_dly(3, 9, 4);
    rb = q_lat.size();
    res_ready = 1'b0;
    go(3, 1000);
    wait_valid(100);
    res_ready = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;
    wait_valid(100);
    chk("t2_idx", 64'(res_run_idx), 64'd1);
    chk("t2_lat", 64'(res_latency), 64'd10);
    repeat (4) @(negedge clock);
    chk("t2_hold_v", 64'(res_valid), 64'd1);
    chk("t2_hold_l", 64'(res_latency), 64'd10);
    chk("t2_hold_i", 64'(res_run_idx), 64'd1);
    chk("t2_hold_s", 64'(res_status), 64'd0);
    res_ready = 1'b1;
    wait_fin(200);
    chk("t2_nrec", 64'(q_lat.size() - rb), 64'd3);
    chk("t2_lat2", 64'(q_lat[rb+2]), 64'd5);
    chk("t2_min", 64'(stat_min), 64'd4);
    chk("t2_max", 64'(stat_max), 64'd10);
    chk("t2_sum", 64'(stat_sum), 64'd19);

    // hung DUT, watchdog at 100
    set_dly(0, 0, 0);
    rb = q_lat.size();
    go(3, 100);
    wait_fin(400);
    chk("t3_nrec", 64'(q_lat.size() - rb), 64'd1);
    chk("t3_st", 64'(q_st[rb]), 64'd1);
    chk("t3_lat", 64'(q_lat[rb]), 64'd101);
    chk("t3_starts", 64'(nstart - base), 64'd1);
    chk("t3_min", 64'(stat_min), 64'hffff_ffff);
    chk("t3_max", 64'(stat_max), 64'd0);
    chk("t3_sum", 64'(stat_sum), 64'd0);

    // abort coincident with done
    set_dly(5, 5, 5);
    rb = q_lat.size();
    d0 = ndone;
    abort_on_done = 1'b1;
    go(3, 1000);
    wait_fin(200);
    abort_on_done = 1'b0;
    chk("t4_nrec", 64'(q_lat.size() - rb), 64'd1);
    chk("t4_st", 64'(q_st[rb]), 64'd2);
    chk("t4_lat", 64'(q_lat[rb]), 64'd6);
    chk("t4_idx", 64'(q_idx[rb]), 64'd0);
    chk("t4_done1", 64'(ndone - d0), 64'd1);
    chk("t4_max", 64'(stat_max), 64'd0);
    chk("t4_sum", 64'(stat_sum), 64'd0);

    // reset in the middle of run 1
    set_dly(50, 50, 50);
    sb = nstart;
    go(3, 1000);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (nstart - sb == 2) begin
        seen = 1;
        break;
      end
    end
    chk("t5_run1", 64'(seen), 64'd1);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_valid", 64'(res_valid), 64'd0);
    chk("t5_dreset", 64'(dut_reset), 64'd1);
    chk("t5_start", 64'(dut_start), 64'd0);
    chk("t5_alldone", 64'(all_done), 64'd0);
    chk("t5_lat", 64'(res_latency), 64'd0);
    chk("t5_min", 64'(stat_min), 64'hffff_ffff);
    chk("t5_max", 64'(stat_max), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    set_dly(2, 2, 2);
    rb = q_lat.size();
    go(1, 1000);
    wait_fin(200);
    chk("t5_nrec", 64'(q_lat.size() - rb), 64'd1);
    chk("t5_idx", 64'(q_idx[rb]), 64'd0);
    chk("t5_lat2", 64'(q_lat[rb]), 64'd3);
    chk("t5_sum", 64'(stat_sum), 64'd3);

    // zero run count, plus a cfg_go while busy
    set_dly(1, 1, 1);
    rb = q_lat.size();
    d0 = ndone;
    go(0, 1000);
    go(5, 1000);
    wait_fin(200);
    chk("t6_nrec", 64'(q_lat.size() - rb), 64'd1);
    chk("t6_lat", 64'(q_lat[rb]), 64'd2);
    chk("t6_starts", 64'(nstart - base), 64'd1);
    chk("t6_done1", 64'(ndone - d0), 64'd1);
    chk("t6_min", 64'(stat_min), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
